// File: rtl/uart_burst_tx.sv
// Buffered UART transmitter: queued words leave as 1..DATA_W/8 back-to-back 8N1 frames.
// A DEPTH-entry request FIFO decouples the producer from the serial line.
module uart_burst_tx #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned MSB_FIRST    = 0,
    localparam int unsigned NB          = DATA_W / 8,
    localparam int unsigned LW          = $clog2(NB + 1),
    localparam int unsigned LVW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [LW-1:0]     req_len,
    output logic              tx_pin_out,
    output logic              busy,
    output logic [LVW-1:0]    fifo_level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Request FIFO
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [LW-1:0]     mem_len  [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVW-1:0]    level_q, level_d;
    logic [LW-1:0]     len_clamped;
    logic              ready_q, ready_d;
    logic              push, pop;

    // Transmit FSM
    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [7:0]        byte_q, byte_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              bit_end;

    assign len_clamped = (req_len > LW'(NB)) ? LW'(NB) : req_len;
    assign push        = req_valid & ready_q;
    assign bit_end     = (timer_q == TW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= req_data;
            mem_len[wr_ptr_q]  <= len_clamped;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVW'(1);
            2'b01:   level_d = level_q - LVW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    // State register plus registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            byte_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        timer_d   = bit_end ? '0 : timer_q + TW'(1);
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        word_d    = word_q;
        byte_d    = byte_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (level_q != '0) begin
                    pop    = 1'b1;
                    word_d = mem_data[rd_ptr_q];
                    cnt_d  = mem_len[rd_ptr_q];
                    idx_d  = (MSB_FIRST != 0) ? IW'(mem_len[rd_ptr_q] - LW'(1)) : '0;
                    // A zero-length entry is simply dropped; the FSM stays idle.
                    if (mem_len[rd_ptr_q] != '0) begin
                        state_d = StStart;
                        byte_d  = mem_data[rd_ptr_q][int'(idx_d)*8 +: 8];
                    end
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) state_d = StStop;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = cnt_q - LW'(1);
                    if (cnt_d != '0) begin
                        state_d = StStart;
                        idx_d   = (MSB_FIRST != 0) ? idx_q - IW'(1) : idx_q + IW'(1);
                        byte_d  = word_q[int'(idx_d)*8 +: 8];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    // Output logic, evaluated on next state so the pins are registered without lag
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = byte_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d  = !((state_d == StIdle) && (level_d == '0));
        ready_d = (level_d < LVW'(DEPTH));
    end

    assign req_ready  = ready_q;
    assign tx_pin_out = tx_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

endmodule
